// File: rtl/io_unit.sv
// I/O unit for cin_int/out: RX bytes are buffered and packed little-endian into
// 32-bit words, and TX bytes are buffered and drained to the UART transmitter.
module io_unit #(
    parameter int unsigned RX_DEPTH = 64,
    parameter int unsigned TX_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_issued,
    input  logic        out_issued,
    input  logic [31:0] out_data,
    output logic [31:0] in_data,
    output logic        in_valid,
    output logic        io_stall,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        rx_overflow
);
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam int unsigned TX_AW = $clog2(TX_DEPTH);

    typedef enum logic [1:0] {IDLE, GATHER, DONE} in_state_t;
    typedef enum logic {T_IDLE, T_GUARD} tx_state_t;

    in_state_t in_state, in_next;
    tx_state_t tx_state, tx_next;

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wptr, rx_rptr;
    logic [RX_AW:0]   rx_count;
    logic             rx_empty, rx_full, rx_wr, rx_pop;

    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wptr, tx_rptr;
    logic [TX_AW:0]   tx_count;
    logic             tx_empty, tx_full, tx_push, tx_pop;

    logic [1:0]       byte_cnt;
    logic [31:0]      word;
    logic             unused_hi;

    assign unused_hi = ^out_data[31:8];

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == (RX_AW + 1)'(RX_DEPTH));
    // A full FIFO still accepts a byte when the head is popped in the same cycle.
    assign rx_wr    = rx_valid & (~rx_full | rx_pop);

    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == (TX_AW + 1)'(TX_DEPTH));
    assign tx_push  = out_issued & ~in_issued & ~tx_full;
    assign tx_pop   = tx_start;

    assign io_stall = (in_issued & (in_state != DONE)) | (out_issued & ~in_issued & tx_full);
    assign in_data  = word;

    always_ff @(posedge clk) begin
        if (rx_wr) rx_mem[rx_wptr] <= rx_data;
        if (tx_push) tx_mem[tx_wptr] <= out_data[7:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_wptr     <= '0;
            rx_rptr     <= '0;
            rx_count    <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (rx_wr) rx_wptr <= rx_wptr + RX_AW'(1);
            if (rx_pop) rx_rptr <= rx_rptr + RX_AW'(1);
            case ({rx_wr, rx_pop})
                2'b10:   rx_count <= rx_count + (RX_AW + 1)'(1);
                2'b01:   rx_count <= rx_count - (RX_AW + 1)'(1);
                default: rx_count <= rx_count;
            endcase
            if (rx_valid && !rx_wr) rx_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + TX_AW'(1);
            if (tx_pop) tx_rptr <= tx_rptr + TX_AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + (TX_AW + 1)'(1);
                2'b01:   tx_count <= tx_count - (TX_AW + 1)'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_state <= IDLE;
            tx_state <= T_IDLE;
        end else begin
            in_state <= in_next;
            tx_state <= tx_next;
        end
    end

    always_comb begin
        in_next  = in_state;
        rx_pop   = 1'b0;
        in_valid = 1'b0;
        case (in_state)
            IDLE: begin
                if (in_issued) in_next = GATHER;
            end
            GATHER: begin
                if (!rx_empty) begin
                    rx_pop = 1'b1;
                    if (byte_cnt == 2'd3) in_next = DONE;
                end
            end
            DONE: begin
                in_valid = 1'b1;
                in_next  = IDLE;
            end
            default: in_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (in_state == IDLE && in_issued) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (rx_pop) begin
            word[{byte_cnt, 3'b000} +: 8] <= rx_mem[rx_rptr];
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    // The guard cycle covers the transmitter's one-cycle tx_busy rise latency.
    always_comb begin
        tx_next  = tx_state;
        tx_start = 1'b0;
        tx_data  = '0;
        case (tx_state)
            T_IDLE: begin
                if (!tx_empty && !tx_busy) begin
                    tx_start = 1'b1;
                    tx_data  = tx_mem[tx_rptr];
                    tx_next  = T_GUARD;
                end
            end
            T_GUARD: tx_next = T_IDLE;
            default: tx_next = T_IDLE;
        endcase
    end
endmodule
